pc_ir_unit: RTL and testbench
=============================

# pc_ir_unit

Program-counter and instruction-register stage of the multicycle CPU: consumes the PC/IR control strobes from the main control FSM and produces the opcode it decodes. Holds the PC, computes the next PC (ALU result, ALUOut, or jump target), and runs the instruction-memory read handshake. It asserts `stall` to freeze the control FSM while a fetch is outstanding, and flags misaligned or timed-out fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TIMEOUT`, 16, maximum wait cycles for `mem_ready` before a fetch is abandoned (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `PCWrite`  in  1  unconditional PC load
- `PCWriteCond`  in  1  PC load qualified by `alu_zero`
- `PCSource`  in  2  next-PC select
- `IorD`  in  1  fetch address select: 0 = PC, 1 = `alu_out`
- `IRWrite`  in  1  fetch request / IR load
- `alu_result`  in  32  combinational ALU output
- `alu_out`  in  32  registered ALUOut
- `alu_zero`  in  1  ALU zero flag
- `mem_rdata`  in  32  instruction memory read data
- `mem_ready`  in  1  read data valid, single-cycle pulse
- `mem_rd_req`  out  1  read request, level, held until `mem_ready`
- `mem_addr`  out  32  read address, stable while `mem_rd_req`
- `pc`  out  32  current PC
- `instr`  out  32  instruction register
- `opCode`  out  6  `instr[31:26]`
- `stall`  out  1  combinational; control FSM holds its state while high
- `fetch_err`  out  1  sticky error flag

## Operation
- Next PC: `PCSource` 00 → `alu_result`; 01 → `alu_out`; 10 → `{pc[31:28], instr[25:0], 2'b00}`; 11 → reserved, PC holds.
- PC load enable: `(PCWrite | (PCWriteCond & alu_zero)) & ~stall`. A load enable with `PCSource`=11 leaves the PC unchanged.
- Fetch FSM states: IDLE, WAIT.
  - IDLE with `IRWrite`=1 and fetch address[1:0]=00: capture the fetch address into the address register, go to WAIT.
  - IDLE with `IRWrite`=1 and a misaligned address: no request is issued, `instr` ← 32'h0 (NOP), `fetch_err` ← 1, stay in IDLE, no stall.
  - WAIT with `mem_ready`=1: `instr` ← `mem_rdata`, go to IDLE.
  - WAIT without `mem_ready` when the wait counter reaches `TIMEOUT`-1: `instr` ← 32'h0, `fetch_err` ← 1, `mem_rd_req` drops, go to IDLE.
- `stall` = (IDLE & `IRWrite` & aligned) | (WAIT & ~`mem_ready`).
- `IRWrite` is ignored while in WAIT; `mem_ready` is ignored outside WAIT.
- `fetch_err` is cleared only by reset.
- Wait counter: clears on entry to WAIT and increments each WAIT cycle. Its width is clog2(`TIMEOUT`), and it never wraps.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `opCode`=0, FSM=IDLE, `mem_rd_req`=0, `mem_addr`=`RESET_PC`, `fetch_err`=0, counter=0, `stall`=0 (with `IRWrite` low).
- Fetch latency:
  - `IRWrite` sampled high in cycle N → `mem_rd_req`=1 from cycle N+1.
  - `mem_ready` in cycle M≥N+1 → `instr` valid in cycle M+1.
  - Zero-wait memory gives a 2-cycle fetch.
- `stall` falls in the `mem_ready` cycle, so the control FSM advances on the same edge that loads `instr`.
- PC loads take effect on the next rising edge. Loads requested while `stall`=1 are dropped; the control FSM re-presents them.
- `mem_addr` is registered and is not affected by PC loads during WAIT.
- Reset asserted mid-WAIT: `mem_rd_req` falls asynchronously, the transaction is abandoned, and a later `mem_ready` is ignored.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (R_TYPE, ADDI, BEQ, BNE, J)
  - `PCSource` encodings (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP)
  - `NOP_INSTR` = 32'h0
  - fetch FSM state typedef
- Sub-module: `ifetch_fsm` contains the fetch FSM, wait counter, `mem_rd_req`/`mem_addr` registers, `stall`, and `fetch_err`. PC and IR registers plus the next-PC mux stay in `pc_ir_unit`.

## Test plan
- Reset release, then `IRWrite` at cycle 1 with `mem_ready` in cycle 2 and `mem_rdata`=32'h2008_0005 → `mem_addr`=0, `instr`=32'h2008_0005 and `opCode`=6'b001000 at cycle 3, `stall` high only in cycle 1.
- `PCWrite`=1, `PCSource`=00, `alu_result`=4 → `pc`=4 next cycle. Then `PCWriteCond`=1, `alu_zero`=0, `PCSource`=01 → `pc` stays 4. Repeat with `alu_zero`=1, `alu_out`=32'h40 → `pc`=32'h40.
- `instr`=32'h0800_0010, `pc`=32'h1000_0000, `PCWrite` with `PCSource`=10 → `pc`=32'h1000_0040.
- Memory withholds `mem_ready` for 5 cycles while `PCWrite` is pulsed during the stall → `stall` high for 5 cycles, `pc` unchanged, `mem_addr` stable, `instr` loaded on ready.
- `TIMEOUT`=16 with no `mem_ready` → `mem_rd_req` drops after 16 WAIT cycles, `instr`=0, `fetch_err`=1 persists until reset. `IorD`=1 with `alu_out`=32'h3 → no request, `fetch_err`=1, `stall`=0.
- Reset asserted in the 2nd WAIT cycle → `mem_rd_req`=0 immediately and `pc`=`RESET_PC`. A `mem_ready` pulse after release leaves `instr`=0.

Source files
------------

// File: rtl/pc_ir_unit_pkg.sv
// Shared CPU definitions: opcodes, next-PC select encodings and the fetch FSM state type.
package cpu_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] J      = 6'b000010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_ir_unit_if.sv
// Instruction-memory read handshake: level request held until a one-cycle ready pulse.
interface pc_ir_unit_if;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_rd_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_rd_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/pc_ir_unit_ifetch_fsm.sv
// Fetch sequencer: issues the memory read, counts wait cycles, raises stall and the sticky error.
module ifetch_fsm
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir_write,
  input  logic [31:0]         fetch_addr,
  pc_ir_unit_if.master        mem,
  output logic                stall,
  output logic                fetch_err,
  output logic                ir_we,
  output logic [31:0]         ir_wdata
);

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic             aligned;

  always_comb begin
    aligned  = (fetch_addr[1:0] == 2'b00);
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    err_d    = err_q;
    stall    = 1'b0;
    ir_we    = 1'b0;
    ir_wdata = NOP_INSTR;

    case (state_q)
      FETCH_IDLE: begin
        if (ir_write) begin
          if (aligned) begin
            state_d = FETCH_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            addr_d  = fetch_addr;
            stall   = 1'b1;
          end else begin
            // Misaligned fetch never reaches memory; IR gets a NOP instead.
            ir_we = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      FETCH_WAIT: begin
        if (mem.mem_ready) begin
          ir_we    = 1'b1;
          ir_wdata = mem.mem_rdata;
          req_d    = 1'b0;
          state_d  = FETCH_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == CNT_LAST) begin
            ir_we   = 1'b1;
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = FETCH_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_rd_req = req_q;
  assign mem.mem_addr   = addr_q;
  assign fetch_err      = err_q;

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR stage of the multicycle CPU: next-PC mux, PC and IR registers, fetch sequencer.
module pc_ir_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCWrite,
  input  logic         PCWriteCond,
  input  logic [1:0]   PCSource,
  input  logic         IorD,
  input  logic         IRWrite,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  alu_out,
  input  logic         alu_zero,
  pc_ir_unit_if.master mem,
  output logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic [5:0]   opCode,
  output logic         stall,
  output logic         fetch_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_addr;
  logic        pc_load;
  logic        ir_we;
  logic [31:0] ir_wdata;

  assign fetch_addr = IorD ? alu_out : pc_q;

  ifetch_fsm #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) u_ifetch (
    .clk        (clk),
    .rst_n      (reset),
    .ir_write   (IRWrite),
    .fetch_addr (fetch_addr),
    .mem        (mem),
    .stall      (stall),
    .fetch_err  (fetch_err),
    .ir_we      (ir_we),
    .ir_wdata   (ir_wdata)
  );

  // Loads during a stall are dropped; the control FSM re-presents them.
  assign pc_load = (PCWrite | (PCWriteCond & alu_zero)) & ~stall;

  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      case (PCSource)
        PCSRC_ALU:    pc_d = alu_result;
        PCSRC_ALUOUT: pc_d = alu_out;
        PCSRC_JUMP:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
        default:      pc_d = pc_q;
      endcase
    end
    instr_d = ir_we ? ir_wdata : instr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc     = pc_q;
  assign instr  = instr_q;
  assign opCode = instr_q[31:26];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit with a cycle-level reference model checked every falling edge.
module tb_pc_ir_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b0, PCWriteCond = 1'b0, IorD = 1'b0, IRWrite = 1'b0, alu_zero = 1'b0;
  logic [1:0]  PCSource = 2'b00;
  logic [31:0] alu_result = '0, alu_out = '0;
  logic [31:0] pc, instr;
  logic [5:0]  opCode;
  logic        stall, fetch_err;

  pc_ir_unit_if mem_if ();

  pc_ir_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .mem         (mem_if),
    .pc          (pc),
    .instr       (instr),
    .opCode      (opCode),
    .stall       (stall),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is either outstanding or not, and counts how long it has waited.
  logic [31:0] m_pc, m_instr, m_addr;
  logic        m_err, m_busy;
  int unsigned m_waited;

  function automatic logic [31:0] m_fa();
    return IorD ? alu_out : m_pc;
  endfunction

  function automatic logic m_stall();
    if (m_busy) return !mem_if.mem_ready;
    return IRWrite && (m_fa() % 4 == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_instr <= '0; m_addr <= RST_PC;
      m_err <= 1'b0; m_busy <= 1'b0; m_waited <= 0;
    end else begin
      if ((PCWrite || (PCWriteCond && alu_zero)) && !m_stall()) begin
        if (PCSource == 2'd0) m_pc <= alu_result;
        else if (PCSource == 2'd1) m_pc <= alu_out;
        else if (PCSource == 2'd2) m_pc <= (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      end
      if (m_busy) begin
        m_waited <= m_waited + 1;
        if (mem_if.mem_ready) begin
          m_instr <= mem_if.mem_rdata; m_busy <= 1'b0;
        end else if (m_waited + 1 == TMO) begin
          m_instr <= '0; m_err <= 1'b1; m_busy <= 1'b0;
        end
      end else if (IRWrite) begin
        if (m_fa() % 4 == 0) begin
          m_busy <= 1'b1; m_addr <= m_fa(); m_waited <= 0;
        end else begin
          m_instr <= '0; m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("opCode", {26'b0, opCode}, {26'b0, m_instr[31:26]});
    chk("mem_rd_req", {31'b0, mem_if.mem_rd_req}, {31'b0, m_busy});
    chk("mem_addr", mem_if.mem_addr, m_addr);
    chk("stall", {31'b0, stall}, {31'b0, m_stall()});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch_now(input logic [31:0] data);
    IRWrite = 1'b1; cyc(1);
    IRWrite = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = data; cyc(1);
    mem_if.mem_ready = 1'b0;
  endtask

  int scnt;

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, mem_if.mem_rd_req}, 32'h0);
    chk("rst_addr", mem_if.mem_addr, RST_PC);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);

    // Zero-wait fetch from PC
    IRWrite = 1'b1; #1 chk("t1_stall_c1", {31'b0, stall}, 32'h1);
    cyc(1);
    IRWrite = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h2008_0005;
    #1 chk("t1_req", {31'b0, mem_if.mem_rd_req}, 32'h1);
    chk("t1_addr", mem_if.mem_addr, 32'h0);
    chk("t1_stall_c2", {31'b0, stall}, 32'h0);
    cyc(1);
    mem_if.mem_ready = 1'b0;
    #1 chk("t1_instr", instr, 32'h2008_0005);
    chk("t1_opcode", {26'b0, opCode}, 32'h08);
    chk("t1_req_low", {31'b0, mem_if.mem_rd_req}, 32'h0);

    // PC sources and conditional load
    PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h4; cyc(1);
    PCWrite = 1'b0; chk("t2_pc_alu", pc, 32'h4);
    PCWriteCond = 1'b1; alu_zero = 1'b0; PCSource = 2'b01; alu_out = 32'h40; cyc(1);
    chk("t2_pc_cond0", pc, 32'h4);
    alu_zero = 1'b1; cyc(1);
    PCWriteCond = 1'b0; alu_zero = 1'b0;
    chk("t2_pc_cond1", pc, 32'h40);
    PCWrite = 1'b1; PCSource = 2'b11; alu_result = 32'h88; cyc(1);
    PCWrite = 1'b0; chk("t2_pc_rsvd", pc, 32'h40);

    // Jump target
    PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h1000_0000; cyc(1);
    PCWrite = 1'b0; IorD = 1'b1; alu_out = 32'h100;
    fetch_now(32'h0800_0010);
    IorD = 1'b0;
    chk("t3_addr", mem_if.mem_addr, 32'h100);
    chk("t3_instr", instr, 32'h0800_0010);
    PCWrite = 1'b1; PCSource = 2'b10; cyc(1);
    PCWrite = 1'b0; chk("t3_pc_jump", pc, 32'h1000_0040);

    // Slow memory with PC loads attempted during the stall
    scnt = 0;
    IRWrite = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCWrite = (i % 2 == 1); PCSource = 2'b00; alu_result = 32'hDEAD_0000;
      #1 if (stall) scnt++;
      cyc(1);
      IRWrite = 1'b0;
    end
    PCWrite = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h1234_5678;
    #1 chk("t4_stall_ready", {31'b0, stall}, 32'h0);
    chk("t4_addr", mem_if.mem_addr, 32'h1000_0040);
    cyc(1);
    mem_if.mem_ready = 1'b0;
    chk("t4_stall_cycles", scnt, 32'd5);
    chk("t4_pc", pc, 32'h1000_0040);
    chk("t4_instr", instr, 32'h1234_5678);

    // Misaligned fetch address
    IorD = 1'b1; alu_out = 32'h3; IRWrite = 1'b1;
    #1 chk("t5_mis_stall", {31'b0, stall}, 32'h0);
    cyc(1);
    IRWrite = 1'b0; IorD = 1'b0;
    chk("t5_mis_req", {31'b0, mem_if.mem_rd_req}, 32'h0);
    chk("t5_mis_err", {31'b0, fetch_err}, 32'h1);
    chk("t5_mis_instr", instr, 32'h0);

    rst_n = 1'b0; #2 rst_n = 1'b1;
    chk("t5_err_cleared", {31'b0, fetch_err}, 32'h0);

    // Timeout
    fetch_now(32'hAAAA_5555);
    IRWrite = 1'b1; cyc(1);
    IRWrite = 1'b0; cyc(15);
    chk("t6_req_last_wait", {31'b0, mem_if.mem_rd_req}, 32'h1);
    cyc(1);
    chk("t6_req_dropped", {31'b0, mem_if.mem_rd_req}, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_err", {31'b0, fetch_err}, 32'h1);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hFFFF_FFFF; cyc(1);
    mem_if.mem_ready = 1'b0; cyc(2);
    chk("t6_late_ready", instr, 32'h0);
    chk("t6_err_sticky", {31'b0, fetch_err}, 32'h1);

    // Reset in the second WAIT cycle
    PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h80; cyc(1);
    PCWrite = 1'b0;
    fetch_now(32'h1111_2222);
    IRWrite = 1'b1; cyc(1);
    IRWrite = 1'b0; cyc(1);
    rst_n = 1'b0;
    #1 chk("t7_req_async", {31'b0, mem_if.mem_rd_req}, 32'h0);
    chk("t7_pc_async", pc, RST_PC);
    @(posedge clk); #2 rst_n = 1'b1;
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF; cyc(1);
    mem_if.mem_ready = 1'b0;
    chk("t7_instr", instr, 32'h0);
    chk("t7_req", {31'b0, mem_if.mem_rd_req}, 32'h0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
